imm_ext_stage: RTL

//  Parametrised, pipelined immediate/operand extender for the decode stage.

---
 rtl/imm_ext_stage.sv | 87 ++++++++
 1 files changed

// File: rtl/imm_ext_stage.sv
// imm_ext_stage: decode-stage immediate extender feeding a 2-entry elastic buffer
// with valid/ready handshakes, flush, and a saturating illegal-mode counter.
module imm_ext_stage #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [2:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err,
   output logic [7:0]       ill_cnt
);
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
   state_t             r_state;
   logic [OUT_W-1:0]   r_data [2];
   logic [TAG_W-1:0]   r_tag  [2];
   logic [1:0]         r_err;
   logic               r_wp;
   logic               r_rp;
   logic [7:0]         r_ill;
   logic [OUT_W-1:0]   w_sext;
   logic [OUT_W-1:0]   w_ext;
   logic               w_ill;
   logic               w_push;
   logic               w_pop;
   assign w_sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
   always_comb begin
      w_ext = '0;
      w_ill = 1'b0;
      case (in_mode)
         3'b000:  w_ext = {{(OUT_W-IN_W){1'b0}}, in_imm};
         3'b010:  w_ext = w_sext;
         3'b001:  w_ext = {in_imm, {(OUT_W-IN_W){1'b0}}};
         3'b011:  w_ext = w_sext << 2;
         3'b100:  w_ext = {{(OUT_W-8){in_imm[7]}}, in_imm[7:0]};
         3'b101:  w_ext = {{(OUT_W-8){1'b0}}, in_imm[7:0]};
         default: w_ill = 1'b1;
      endcase
   end
   // Held low through reset so nothing is accepted before the buffer is live.
   assign in_ready  = rst_n && (r_state != FULL) && !flush;
   assign out_valid = r_state != EMPTY;
   assign out_data  = r_data[r_rp];
   assign out_tag   = r_tag[r_rp];
   assign out_err   = r_err[r_rp];
   assign ill_cnt   = r_ill;
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= EMPTY;
         r_data  <= '{default: '0};
         r_tag   <= '{default: '0};
         r_err   <= '0;
         r_wp    <= 1'b0;
         r_rp    <= 1'b0;
         r_ill   <= '0;
      end else if (flush) begin
         r_state <= EMPTY;
         r_wp    <= 1'b0;
         r_rp    <= 1'b0;
      end else begin
         if (w_push) begin
            r_data[r_wp] <= w_ext;
            r_tag[r_wp]  <= in_tag;
            r_err[r_wp]  <= w_ill;
            r_wp         <= ~r_wp;
         end
         if (w_pop)
            r_rp <= ~r_rp;
         r_state <= (w_push && !w_pop) ? ((r_state == EMPTY) ? ONE : FULL) :
                    (!w_push && w_pop) ? ((r_state == FULL) ? ONE : EMPTY) : r_state;
         if (w_push && w_ill && r_ill != 8'hFF)
            r_ill <= r_ill + 8'd1;
      end
   end
endmodule
